// File: rtl/bclk_training_ctrl.sv
// Fabric-side BCLK training sequencer: sweeps the IOD delay line, locates the unstable window
// around the BCLK edge, then parks the delay line at edge centre plus a fixed offset.
module bclk_training_ctrl #(
  parameter int TAP_MAX       = 127,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CNT    = 16,
  parameter int OFFSET_TAPS   = 32
) (
  input  logic       FAB_CLK,
  input  logic       SYNC_RST,
  input  logic       TRAIN_START,
  input  logic [7:0] RX_DATA,
  input  logic       EYE_MONITOR_EARLY,
  input  logic       EYE_MONITOR_LATE,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic       EYE_MONITOR_CLEAR_FLAGS,
  output logic [7:0] TAP_POS,
  output logic [7:0] EDGE_TAP,
  output logic       TRAIN_BUSY,
  output logic       TRAIN_DONE,
  output logic [1:0] TRAIN_ERR
);

  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CNT) ? SETTLE_CYCLES : SAMPLE_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CNT - 1);
  localparam logic [7:0] TAP_MAX_V = 8'(TAP_MAX);
  localparam logic [8:0] TAP_MAX_9 = 9'(TAP_MAX);
  localparam logic [8:0] OFFSET_9  = 9'(OFFSET_TAPS);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_STEP, S_SEEK, S_DONE, S_ERR
  } state_t;

  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_tap, r_edge_tap, r_edge_start, r_last_unstable, r_word0;
  logic [8:0]       r_target;
  logic             r_edge_found, r_seek_mode, r_mismatch, r_dir;
  logic [1:0]       r_err, w_err_nxt;
  logic             w_load, w_move, w_dir, w_clr, w_busy, w_unstable;
  logic [8:0]       w_edge_sum, w_target;
  logic [7:0]       w_edge_ctr;

  assign w_busy     = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
  assign w_unstable = r_mismatch | EYE_MONITOR_EARLY | EYE_MONITOR_LATE |
                      (r_word0 == 8'h00) | (r_word0 == 8'hFF);
  assign w_edge_sum = {1'b0, r_edge_start} + {1'b0, r_last_unstable};
  assign w_edge_ctr = 8'(w_edge_sum >> 1);
  assign w_target   = {1'b0, w_edge_ctr} + OFFSET_9;

  always_comb begin
    w_nxt     = r_state;
    w_err_nxt = r_err;
    w_load    = 1'b0;
    w_move    = 1'b0;
    w_dir     = r_dir;
    w_clr     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (TRAIN_START) begin
          w_nxt     = S_LOAD;
          w_err_nxt = 2'b00;
        end
      end
      S_LOAD: begin
        w_load = 1'b1;
        w_nxt  = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) w_nxt = r_seek_mode ? S_SEEK : S_SAMPLE;
      end
      S_SAMPLE: begin
        w_clr = (r_cnt == '0);
        if (r_cnt == SAMPLE_LAST) w_nxt = S_EVAL;
      end
      S_EVAL: begin
        // A stable tap after an unstable run closes the edge window.
        if (!w_unstable && r_edge_found) begin
          if (w_target > TAP_MAX_9) begin
            w_nxt     = S_ERR;
            w_err_nxt = 2'b11;
          end else begin
            w_nxt = S_SEEK;
          end
        end else if (r_tap == TAP_MAX_V) begin
          w_nxt     = S_ERR;
          w_err_nxt = 2'b01;
        end else begin
          w_nxt = S_STEP;
        end
      end
      S_STEP: begin
        w_move = 1'b1;
        w_dir  = 1'b1;
        w_nxt  = S_SETTLE;
      end
      S_SEEK: begin
        if ({1'b0, r_tap} == r_target) begin
          w_nxt = S_DONE;
        end else begin
          w_move = 1'b1;
          w_dir  = (r_target > {1'b0, r_tap});
          w_nxt  = S_SETTLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
    // A saturated delay line overrides everything else and suppresses the pending pulse.
    if (w_busy && DELAY_LINE_OUT_OF_RANGE) begin
      w_nxt     = S_ERR;
      w_err_nxt = 2'b10;
      w_load    = 1'b0;
      w_move    = 1'b0;
      w_dir     = r_dir;
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_tap           <= 8'd0;
      r_edge_tap      <= 8'd0;
      r_target        <= 9'd0;
      r_edge_found    <= 1'b0;
      r_seek_mode     <= 1'b0;
      r_dir           <= 1'b1;
      r_err           <= 2'b00;
      r_last_unstable <= 8'd0;
    end else begin
      r_state <= w_nxt;
      r_err   <= w_err_nxt;
      r_dir   <= w_dir;
      if (w_nxt != r_state || !(r_state == S_SETTLE || r_state == S_SAMPLE)) r_cnt <= '0;
      else r_cnt <= r_cnt + 1'b1;
      if (w_move) r_tap <= w_dir ? r_tap + 8'd1 : r_tap - 8'd1;
      case (r_state)
        S_LOAD: begin
          r_tap           <= 8'd0;
          r_edge_found    <= 1'b0;
          r_last_unstable <= 8'd0;
          r_seek_mode     <= 1'b0;
        end
        S_EVAL: begin
          if (w_unstable) begin
            if (!r_edge_found) r_edge_found <= 1'b1;
            r_last_unstable <= r_tap;
          end else if (r_edge_found) begin
            r_edge_tap  <= w_edge_ctr;
            r_target    <= w_target;
            r_seek_mode <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath captures, no reset needed.
  always_ff @(posedge FAB_CLK) begin
    if (r_state == S_SAMPLE) begin
      if (r_cnt == '0) begin
        r_word0    <= RX_DATA;
        r_mismatch <= 1'b0;
      end else if (RX_DATA != r_word0) begin
        r_mismatch <= 1'b1;
      end
    end
    if (r_state == S_EVAL && w_unstable && !r_edge_found) r_edge_start <= r_tap;
  end

  assign DELAY_LINE_LOAD         = w_load;
  assign DELAY_LINE_MOVE         = w_move;
  assign DELAY_LINE_DIRECTION    = w_dir;
  assign EYE_MONITOR_CLEAR_FLAGS = w_clr;
  assign TAP_POS                 = r_tap;
  assign EDGE_TAP                = r_edge_tap;
  assign TRAIN_BUSY              = w_busy;
  assign TRAIN_DONE              = (r_state == S_DONE);
  assign TRAIN_ERR               = r_err;

endmodule
